// File: rtl/amp_config_seq_if.sv
// Control and SPI pin bundle between the amplifier state controller, the
// register-table lookup and the configuration sequencer.
interface amp_config_seq_if #(
  parameter int IDX_W = 3
);
  logic             send_config_in;
  logic [IDX_W-1:0] cfg_idx_out;
  logic [15:0]      cfg_word_in;
  logic             spi_csn_out;
  logic             spi_sclk_out;
  logic             spi_mosi_out;
  logic             busy_out;
  logic             done_out;
  logic [IDX_W:0]   frames_out;

  modport slave (
    input  send_config_in,
    input  cfg_word_in,
    output cfg_idx_out,
    output spi_csn_out,
    output spi_sclk_out,
    output spi_mosi_out,
    output busy_out,
    output done_out,
    output frames_out
  );

  modport master (
    output send_config_in,
    output cfg_word_in,
    input  cfg_idx_out,
    input  spi_csn_out,
    input  spi_sclk_out,
    input  spi_mosi_out,
    input  busy_out,
    input  done_out,
    input  frames_out
  );
endinterface

// File: rtl/amp_config_seq.sv
// Walks a register table and shifts each 16-bit entry to the amplifier over a
// mode-0, MSB-first SPI link; all outputs come straight from flops.
module amp_config_seq #(
  parameter int NUM_REGS = 8,
  parameter int CLK_DIV  = 4,
  parameter int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic           clk_in,
  input  logic           reset,
  amp_config_seq_if.slave bus
);

  localparam int PH_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int FR_W = IDX_W + 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(CLK_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [15:0]      END_MARK = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             req_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FR_W-1:0]  frames_q, frames_d;
  logic [3:0]       bit_q, bit_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [15:0]      shreg_q, shreg_d;
  logic             csn_q, csn_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      idx_q    <= '0;
      frames_q <= '0;
      bit_q    <= '0;
      ph_q     <= '0;
      csn_q    <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= bus.send_config_in;
      idx_q    <= idx_d;
      frames_q <= frames_d;
      bit_q    <= bit_d;
      ph_q     <= ph_d;
      csn_q    <= csn_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Shift data carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk_in) begin
    shreg_q <= shreg_d;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frames_d = frames_q;
    bit_d    = bit_q;
    ph_d     = ph_q;
    shreg_d  = shreg_q;

    unique case (state_q)
      S_IDLE: begin
        ph_d  = '0;
        bit_d = '0;
        if (bus.send_config_in && !req_q) begin
          idx_d    = '0;
          frames_d = '0;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        shreg_d = bus.cfg_word_in;
        ph_d    = '0;
        bit_d   = '0;
        state_d = (bus.cfg_word_in == END_MARK) ? S_DONE : S_SHIFT;
      end

      S_SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (bit_q == 4'd15) begin
            frames_d = frames_q + FR_W'(1);
            state_d  = S_GAP;
          end else begin
            bit_d   = bit_q + 4'd1;
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      // A dropped request is only honoured here, so frames are never cut short.
      S_GAP: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (!bus.send_config_in) begin
            state_d = S_IDLE;
          end else if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LOAD;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      S_DONE: begin
        if (!bus.send_config_in) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so they land in flops together with it.
  always_comb begin
    csn_d  = (state_d != S_SHIFT);
    sclk_d = (state_d == S_SHIFT) && (ph_d >= PH_HIGH);
    mosi_d = (state_d == S_SHIFT) ? shreg_d[15] : 1'b0;
    busy_d = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  assign bus.cfg_idx_out  = idx_q;
  assign bus.frames_out   = frames_q;
  assign bus.spi_csn_out  = csn_q;
  assign bus.spi_sclk_out = sclk_q;
  assign bus.spi_mosi_out = mosi_q;
  assign bus.busy_out     = busy_q;
  assign bus.done_out     = done_q;

endmodule

// File: tb/tb_amp_config_seq.sv
// Bench for amp_config_seq: table-driven sequences, hand-written corner cases
// and randomized tables/aborts against a frame-level timing model.
module tb_amp_config_seq;

  localparam int NR    = 4;
  localparam int CD    = 2;
  localparam int IW    = 2;
  localparam int FRAME = 1 + 34 * CD;

  typedef logic [NR-1:0][15:0] table_t;

  typedef struct {
    table_t w;
    int     abort_at;
    int     frames;
    int     idx;
    int     lat;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  table_t tbl;

  int tests = 0;
  int fails = 0;

  amp_config_seq_if #(.IDX_W(IW)) bus ();

  amp_config_seq #(
    .NUM_REGS(NR),
    .CLK_DIV (CD)
  ) dut (
    .clk_in(clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.cfg_word_in = tbl[bus.cfg_idx_out];

  // SPI decoder on the falling edge, away from the DUT's update edge
  logic [15:0] got[$];
  int          bits[$];
  int          fall_t[$];
  int          ncyc = 0;
  int          bitcnt = 0;
  int          viol = 0;
  logic [15:0] shw = '0;
  logic        p_csn = 1'b1;
  logic        p_sclk = 1'b0;
  logic        p_mosi = 1'b0;

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (!bus.spi_csn_out && p_csn) begin
      fall_t.push_back(ncyc);
      bitcnt <= 0;
      shw    <= '0;
    end
    if (!bus.spi_csn_out && bus.spi_sclk_out && !p_sclk) begin
      shw    <= {shw[14:0], bus.spi_mosi_out};
      bitcnt <= bitcnt + 1;
    end
    if (bus.spi_sclk_out && p_sclk && (bus.spi_mosi_out != p_mosi)) viol <= viol + 1;
    if (bus.spi_csn_out && bus.spi_sclk_out) viol <= viol + 1;
    if (bus.spi_csn_out && !p_csn) begin
      got.push_back(shw);
      bits.push_back(bitcnt);
    end
    p_csn  <= bus.spi_csn_out;
    p_sclk <= bus.spi_sclk_out;
    p_mosi <= bus.spi_mosi_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic table_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
    table_t t;
    t[0] = a;
    t[1] = b;
    t[2] = c;
    t[3] = d;
    return t;
  endfunction

  // Raise the request from IDLE and follow the sequence; abort_at<0 runs to DONE.
  task automatic run_seq(input table_t t, input int abort_at, input int exp_frames,
                         input int exp_idx, input int exp_lat, input string nm);
    int   gb, fb, c, n;
    logic csn1;
    gb   = got.size();
    fb   = fall_t.size();
    csn1 = 1'b1;
    tbl  = t;
    bus.send_config_in = 1'b1;
    tick();
    chk({nm, " load_busy"}, 32'(bus.busy_out), 32'd1);
    chk({nm, " load_csn"}, 32'(bus.spi_csn_out), 32'd1);
    chk({nm, " load_frames"}, 32'(bus.frames_out), 32'd0);
    chk({nm, " load_idx"}, 32'(bus.cfg_idx_out), 32'd0);
    c = 0;
    while (c < 2000) begin
      tick();
      c++;
      if (c == 1) csn1 = bus.spi_csn_out;
      if (c == abort_at) bus.send_config_in = 1'b0;
      if (abort_at < 0 && bus.done_out) break;
      if (abort_at >= 0 && c > abort_at && !bus.busy_out && !bus.done_out) break;
    end
    chk({nm, " timeout"}, 32'(c < 2000), 32'd1);
    if (t[0] != 16'hFFFF) chk({nm, " csn_latency"}, 32'(csn1), 32'd0);
    if (abort_at < 0) begin
      chk({nm, " done_lat"}, 32'(c), 32'(exp_lat));
      chk({nm, " done"}, 32'(bus.done_out), 32'd1);
    end else begin
      chk({nm, " abort_done"}, 32'(bus.done_out), 32'd0);
    end
    chk({nm, " frames"}, 32'(bus.frames_out), 32'(exp_frames));
    chk({nm, " idx"}, 32'(bus.cfg_idx_out), 32'(exp_idx));
    n = got.size() - gb;
    chk({nm, " nwords"}, 32'(n), 32'(exp_frames));
    for (int i = 0; i < n && i < exp_frames; i++) begin
      chk({nm, " word"}, 32'(got[gb + i]), 32'(t[i]));
      chk({nm, " bits"}, 32'(bits[gb + i]), 32'd16);
    end
    for (int i = fb + 1; i < fall_t.size(); i++)
      chk({nm, " frame_period"}, 32'(fall_t[i] - fall_t[i - 1]), 32'(FRAME));
  endtask

  task automatic finish_seq(input int exp_frames, input string nm);
    bus.send_config_in = 1'b0;
    tick();
    chk({nm, " done_clear"}, 32'(bus.done_out), 32'd0);
    chk({nm, " idle_busy"}, 32'(bus.busy_out), 32'd0);
    chk({nm, " frames_held"}, 32'(bus.frames_out), 32'(exp_frames));
    tick();
  endtask

  vec_t   vecs[8];
  table_t full_t;
  table_t rt;
  int     ab, len, cap, k, fr, ix, lat, fb, c;

  initial begin
    full_t = mk(16'hA501, 16'h3C02, 16'h0003, 16'hFF04);
    vecs[0] = '{full_t, -1, 4, 3, NR * FRAME};
    vecs[1] = '{mk(16'hA501, 16'hFFFF, 16'h0003, 16'hFF04), -1, 1, 1, FRAME + 1};
    vecs[2] = '{mk(16'hFFFF, 16'h1111, 16'h2222, 16'h3333), -1, 0, 0, 1};
    vecs[3] = '{mk(16'h1234, 16'h8001, 16'h7FFE, 16'hFFFF), -1, 3, 3, 3 * FRAME + 1};
    vecs[4] = '{full_t, FRAME + 1 + 16 * CD, 2, 1, 0};
    vecs[5] = '{full_t, FRAME - 1, 1, 0, 0};
    vecs[6] = '{full_t, FRAME, 2, 1, 0};
    vecs[7] = '{mk(16'h5555, 16'hFFFF, 16'h0000, 16'h0000), FRAME, 1, 1, 0};

    bus.send_config_in = 1'b0;
    tbl = full_t;
    tick();
    tick();
    chk("rst csn", 32'(bus.spi_csn_out), 32'd1);
    chk("rst sclk", 32'(bus.spi_sclk_out), 32'd0);
    chk("rst mosi", 32'(bus.spi_mosi_out), 32'd0);
    chk("rst busy", 32'(bus.busy_out), 32'd0);
    chk("rst done", 32'(bus.done_out), 32'd0);
    chk("rst idx", 32'(bus.cfg_idx_out), 32'd0);
    chk("rst frames", 32'(bus.frames_out), 32'd0);
    rst = 1'b0;
    tick();
    tick();

    for (int v = 0; v < 8; v++) begin
      run_seq(vecs[v].w, vecs[v].abort_at, vecs[v].frames, vecs[v].idx, vecs[v].lat, $sformatf("vec%0d", v));
      if (vecs[v].abort_at < 0) finish_seq(vecs[v].frames, $sformatf("vec%0d", v));
      else tick();
    end

    // level held after DONE must not start another pass
    run_seq(full_t, -1, 4, 3, NR * FRAME, "hold");
    fb = fall_t.size();
    repeat (500) tick();
    chk("hold no_csn", 32'(fall_t.size()), 32'(fb));
    chk("hold done", 32'(bus.done_out), 32'd1);
    chk("hold busy", 32'(bus.busy_out), 32'd0);
    finish_seq(4, "hold");
    run_seq(full_t, -1, 4, 3, NR * FRAME, "restart");
    finish_seq(4, "restart");

    // reset during frame 0, bit 10
    fb = fall_t.size();
    bus.send_config_in = 1'b1;
    c = 0;
    while (c < 500 && !(fall_t.size() == fb + 1 && bitcnt == 10)) begin
      tick();
      c++;
    end
    chk("midrst reach", 32'(c < 500), 32'd1);
    rst = 1'b1;
    bus.send_config_in = 1'b0;
    tick();
    chk("midrst csn", 32'(bus.spi_csn_out), 32'd1);
    chk("midrst sclk", 32'(bus.spi_sclk_out), 32'd0);
    chk("midrst busy", 32'(bus.busy_out), 32'd0);
    chk("midrst idx", 32'(bus.cfg_idx_out), 32'd0);
    chk("midrst frames", 32'(bus.frames_out), 32'd0);
    rst = 1'b0;
    tick();
    run_seq(full_t, -1, 4, 3, NR * FRAME, "after_rst");
    finish_seq(4, "after_rst");

    // random tables and abort points against the frame-level timing model
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NR; i++)
        rt[i] = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 300)) : -1;
      len = 0;
      while (len < NR && rt[len] != 16'hFFFF) len++;
      cap = (len == NR) ? NR - 1 : len;
      if (ab < 0) k = NR;
      else begin
        k = 0;
        while (k * FRAME + FRAME - 1 < ab) k++;
      end
      fr  = (k + 1 < len) ? k + 1 : len;
      ix  = (k < cap) ? k : cap;
      lat = (len == NR) ? NR * FRAME : len * FRAME + 1;
      run_seq(rt, ab, fr, ix, lat, $sformatf("rand%0d", r));
      if (ab < 0) finish_seq(fr, $sformatf("rand%0d", r));
      else tick();
    end

    tick();
    chk("spi timing", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/amp_config_seq.md
# amp_config_seq

Serial configuration sequencer for the class-D amplifier front end. When the amplifier state controller raises its send-config request, this block walks a caller-supplied register table and shifts each 16-bit entry to the amplifier over a 3-wire SPI-style link (mode 0, MSB first). It reports busy/done status back to the state controller. It sits between the state controller and the amplifier control pins, next to the timer.

## Interface
- NUM_REGS, 8: number of table entries per sequence (≥1).
- CLK_DIV, 4: clk_in cycles per SCLK half-period (≥1).
- IDX_W, $clog2(NUM_REGS) (min 1): table index width.
- clk_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- send_config_in  input  1  request level from the state controller; a rising edge starts a sequence, and a low level aborts.
- cfg_idx_out  output  IDX_W  table index currently requested.
- cfg_word_in  input  16  table entry for cfg_idx_out (combinational lookup, valid the same cycle); 16'hFFFF is the end-of-table marker.
- spi_csn_out  output  1  chip select, active low.
- spi_sclk_out  output  1  serial clock, idles low.
- spi_mosi_out  output  1  serial data.
- busy_out  output  1  high from LOAD through the last GAP.
- done_out  output  1  sequence completed; held until send_config_in falls.
- frames_out  output  IDX_W+1  frames fully sent in the current or last sequence.

## Operation
- States: IDLE, LOAD, SHIFT, GAP, DONE.
- IDLE:
  - Register send_config_in each cycle.
  - A start condition is send_config_in=1 with the registered previous value 0.
  - On a start: index←0, frames←0, go to LOAD.
  - A level held high never retriggers.
- LOAD (1 cycle):
  - Capture cfg_word_in into the shift register.
  - If the captured word is 16'hFFFF, go to DONE without asserting CSN.
  - Otherwise go to SHIFT and drive spi_csn_out low.
- SHIFT:
  - 16 bits, MSB first, 2·CLK_DIV cycles per bit.
  - Low phase (CLK_DIV cycles): SCLK=0, MOSI=current bit, with MOSI updated on entry to the low phase.
  - High phase (CLK_DIV cycles): SCLK=1, MOSI stable.
  - After bit 0's high phase, go to GAP with CSN=1 and SCLK=0.
- GAP (2·CLK_DIV cycles): CSN high; frames+1 on entry. On exit:
  - If send_config_in=0: go to IDLE (abort; done stays 0).
  - Else if index=NUM_REGS-1: go to DONE.
  - Else: index+1, go to LOAD.
- DONE: done_out=1 and busy_out=0. When send_config_in=0, go to IDLE and clear done_out.
- Abort rule: send_config_in falling during LOAD or SHIFT does not truncate the frame. The frame completes, and the abort takes effect at GAP exit. A falling edge in LOAD on the FFFF marker goes to DONE, then to IDLE on the next cycle.
- frames_out holds its value in IDLE and clears only on a new start.
- cfg_idx_out always equals the internal index.

## Timing
- Reset values: spi_csn_out=1, spi_sclk_out=0, spi_mosi_out=0, busy_out=0, done_out=0, cfg_idx_out=0, frames_out=0, state=IDLE.
- Reset mid-frame forces these values on the next edge. A truncated frame on the wire is acceptable.
- All outputs are registered, with no combinational path from input to output.
- Start latency: rising edge of send_config_in sampled at cycle N gives LOAD at N+1 and CSN low at N+2.
- Per frame: LOAD 1 + SHIFT 32·CLK_DIV + GAP 2·CLK_DIV = 1+34·CLK_DIV cycles (137 at the default CLK_DIV=4).
- Full sequence: NUM_REGS·(1+34·CLK_DIV) cycles from the first LOAD to done_out high.
- MOSI setup before each SCLK rise is CLK_DIV cycles; hold after each rise is CLK_DIV cycles.
- CSN falls CLK_DIV cycles before the first SCLK rise and rises CLK_DIV cycles after the last SCLK rise.
- Counter widths: the bit counter is 4 bits and the phase counter spans 0..2·CLK_DIV-1. There is no wrap of the index past NUM_REGS-1.

## Test plan
- **Full sequence** (NUM_REGS=4, CLK_DIV=2, table 16'hA501, 16'h3C02, 16'h0003, 16'hFF04): pulse send_config_in high and hold it. Required:
  - The SPI decoder captures the four words in order.
  - Each frame is 69 cycles.
  - done_out rises 276 cycles after the first LOAD, with frames_out=4.
- **Early end** (table entry 1 = 16'hFFFF): one frame is sent, then done_out=1 with frames_out=1, and CSN never falls a second time.
- **Abort**: drop send_config_in at bit 7 of frame 1. Required:
  - Frame 1 completes all 16 bits.
  - The block returns to IDLE after GAP with frames_out=2 and done_out=0.
- **Reset mid-SHIFT** (frame 0, bit 10): the next cycle shows CSN=1, SCLK=0, busy_out=0, cfg_idx_out=0. A fresh rising edge restarts from index 0.
- **No retrigger**: hold send_config_in high after DONE for 500 cycles; no CSN activity.
- **Restart**: drop then raise send_config_in; done_out clears, and the full sequence repeats identically with frames_out restarting at 0.
